// File: rtl/psram_axi4_mst_fsm.sv
// AXI4 master burst engine. Turns one user command plus write/read beat
// streams into a single AXI4 INCR burst. Only one transaction is in flight
// at a time, so reads and writes never overlap.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif
`ifndef AXI4_WSTRB_WIDTH
`define AXI4_WSTRB_WIDTH 8
`endif
`ifndef AXI4_DATA_BLOG
`define AXI4_DATA_BLOG 3
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

module psram_axi4_mst_fsm #(
  parameter int MST_ID       = 0,
  parameter bit BOUNDARY_CHK = 1'b1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  // user command / data side
  input  logic                          usr_req_i,
  output logic                          usr_ready_o,
  input  logic                          usr_wen_i,
  input  logic [`AXI4_ADDR_WIDTH-1:0]   usr_addr_i,
  input  logic [7:0]                    usr_len_i,
  input  logic [`AXI4_DATA_WIDTH-1:0]   usr_wdat_i,
  input  logic [`AXI4_WSTRB_WIDTH-1:0]  usr_wstrb_i,
  input  logic                          usr_wvalid_i,
  output logic                          usr_wready_o,
  output logic [`AXI4_DATA_WIDTH-1:0]   usr_rdat_o,
  output logic                          usr_rvalid_o,
  input  logic                          usr_rready_i,
  output logic                          usr_done_o,
  output logic                          usr_err_o,
  // AXI4 write address
  output logic [`AXI4_ID_WIDTH-1:0]     awid,
  output logic [`AXI4_ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic                          awlock,
  output logic [3:0]                    awcache,
  output logic [2:0]                    awprot,
  output logic [3:0]                    awqos,
  output logic [3:0]                    awregion,
  output logic [`AXI4_USER_WIDTH-1:0]   awuser,
  output logic                          awvalid,
  input  logic                          awready,
  // AXI4 write data
  output logic [`AXI4_DATA_WIDTH-1:0]   wdata,
  output logic [`AXI4_WSTRB_WIDTH-1:0]  wstrb,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  // AXI4 write response
  input  logic [`AXI4_ID_WIDTH-1:0]     bid,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready,
  // AXI4 read address
  output logic [`AXI4_ID_WIDTH-1:0]     arid,
  output logic [`AXI4_ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arlock,
  output logic [3:0]                    arcache,
  output logic [2:0]                    arprot,
  output logic [3:0]                    arqos,
  output logic [3:0]                    arregion,
  output logic [`AXI4_USER_WIDTH-1:0]   aruser,
  output logic                          arvalid,
  input  logic                          arready,
  // AXI4 read data
  input  logic [`AXI4_ID_WIDTH-1:0]     rid,
  input  logic [`AXI4_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready
);

  localparam logic [`AXI4_ID_WIDTH-1:0] ID_C = MST_ID[`AXI4_ID_WIDTH-1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic [`AXI4_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                    len_q, len_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic                          err_q, err_d;

  // End offset of the requested burst within its 4KB page; 20 bits cover
  // 4095 + 256 beats * up to 128-byte beats without overflow.
  logic [19:0] span;
  logic        cross_4k;
  logic        last_beat;

  assign span      = {8'd0, usr_addr_i[11:0]} + ((20'(usr_len_i) + 20'd1) << `AXI4_DATA_BLOG);
  assign cross_4k  = BOUNDARY_CHK && (span > 20'd4096);
  assign last_beat = (cnt_q == len_q);

  // Address/len are held in registers so AR/AW stay stable until accepted.
  assign awid     = ID_C;
  assign awaddr   = addr_q;
  assign awlen    = len_q;
  assign awsize   = 3'(`AXI4_DATA_BLOG);
  assign awburst  = 2'b01;
  assign awlock   = 1'b0;
  assign awcache  = '0;
  assign awprot   = '0;
  assign awqos    = '0;
  assign awregion = '0;
  assign awuser   = '0;
  assign arid     = ID_C;
  assign araddr   = addr_q;
  assign arlen    = len_q;
  assign arsize   = 3'(`AXI4_DATA_BLOG);
  assign arburst  = 2'b01;
  assign arlock   = 1'b0;
  assign arcache  = '0;
  assign arprot   = '0;
  assign arqos    = '0;
  assign arregion = '0;
  assign aruser   = '0;

  // Data buses are pure pass-through; only the handshakes are gated by state.
  assign wdata      = usr_wdat_i;
  assign wstrb      = usr_wstrb_i;
  assign usr_rdat_o = rdata;

  // State and transaction registers; reset drops every valid at once since
  // all handshake outputs decode from state_q.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state, register updates and handshake outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    usr_ready_o  = 1'b0;
    usr_wready_o = 1'b0;
    usr_rvalid_o = 1'b0;
    usr_done_o   = 1'b0;
    usr_err_o    = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    wlast        = 1'b0;
    bready       = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Held low while reset is asserted so no command is taken then.
        usr_ready_o = aresetn;
        if (usr_req_i) begin
          addr_d = usr_addr_i;
          len_d  = usr_len_i;
          cnt_d  = '0;
          err_d  = 1'b0;
          if (cross_4k) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = usr_wen_i ? S_AW : S_AR;
          end
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        rready       = usr_rready_i;
        usr_rvalid_o = rvalid;
        if (rvalid && usr_rready_i) begin
          cnt_d = cnt_q + 8'd1;
          // An early or missing rlast is flagged but the beat count,
          // not rlast, decides when the burst is over.
          if (rresp != 2'b00 || rid != ID_C || rlast != last_beat) err_d = 1'b1;
          if (last_beat) state_d = S_DONE;
        end
      end
      S_AW: begin
        awvalid = 1'b1;
        if (awready) state_d = S_W;
      end
      S_W: begin
        wvalid       = usr_wvalid_i;
        usr_wready_o = wready;
        wlast        = last_beat;
        if (usr_wvalid_i && wready) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = S_B;
        end
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) begin
          if (bresp != 2'b00 || bid != ID_C) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        usr_done_o = 1'b1;
        usr_err_o  = err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_psram_axi4_mst_fsm.sv
// Directed bench for the AXI4 master burst engine: the bench plays both the
// user and a hand-driven AXI4 slave, with expected values written inline.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif
`ifndef AXI4_WSTRB_WIDTH
`define AXI4_WSTRB_WIDTH 8
`endif
`ifndef AXI4_DATA_BLOG
`define AXI4_DATA_BLOG 3
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

module tb_psram_axi4_mst_fsm;
  localparam int AW = `AXI4_ADDR_WIDTH;
  localparam int DW = `AXI4_DATA_WIDTH;
  localparam int SW = `AXI4_WSTRB_WIDTH;
  localparam int IW = `AXI4_ID_WIDTH;
  localparam int UW = `AXI4_USER_WIDTH;

  logic aclk, aresetn;
  logic usr_req, usr_ready, usr_wen, usr_wvalid, usr_wready, usr_rvalid, usr_rready, usr_done, usr_err;
  logic [AW-1:0] usr_addr;
  logic [7:0]    usr_len;
  logic [DW-1:0] usr_wdat, usr_rdat;
  logic [SW-1:0] usr_wstrb;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize, awprot, arprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awlock, arlock;
  logic [3:0]    awcache, arcache, awqos, arqos, awregion, arregion;
  logic [UW-1:0] awuser, aruser;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;

  int n_run = 0;
  int n_fail = 0;

  psram_axi4_mst_fsm #(.MST_ID(0), .BOUNDARY_CHK(1'b1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .usr_req_i(usr_req), .usr_ready_o(usr_ready), .usr_wen_i(usr_wen),
    .usr_addr_i(usr_addr), .usr_len_i(usr_len),
    .usr_wdat_i(usr_wdat), .usr_wstrb_i(usr_wstrb), .usr_wvalid_i(usr_wvalid), .usr_wready_o(usr_wready),
    .usr_rdat_o(usr_rdat), .usr_rvalid_o(usr_rvalid), .usr_rready_i(usr_rready),
    .usr_done_o(usr_done), .usr_err_o(usr_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos), .awregion(awregion),
    .awuser(awuser), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos), .arregion(arregion),
    .aruser(aruser), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [7:0] len);
    chk("cmd_ready", usr_ready, 1'b1);
    usr_req  = 1'b1;
    usr_wen  = wen;
    usr_addr = addr;
    usr_len  = len;
    cyc();
    usr_req  = 1'b0;
  endtask

  // Slave returns n beats; rlast on the final beat and also on beat 'early'.
  task automatic read_beats(input int n, input int early);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d          = 64'hD00D_0000_0000_0000 | 64'(i);
      rvalid     = 1'b1;
      rdata      = d;
      rlast      = (i == n - 1) || (i == early);
      usr_rready = 1'b1;
      #1;
      chk("r_uvalid", usr_rvalid, 1'b1);
      chk("r_udata", usr_rdat, d);
      chk("r_rready", rready, 1'b1);
      chk("r_no_early_done", usr_done, 1'b0);
      cyc();
    end
    rvalid     = 1'b0;
    rlast      = 1'b0;
    usr_rready = 1'b0;
  endtask

  task automatic finish_done(input logic exp_err);
    chk("done_pulse", usr_done, 1'b1);
    chk("done_err", usr_err, exp_err);
    cyc();
    chk("done_one_cycle", usr_done, 1'b0);
    chk("back_idle", usr_ready, 1'b1);
  endtask

  initial begin
    int beats;
    aresetn = 1'b0;
    usr_req = 0; usr_wen = 0; usr_addr = '0; usr_len = '0;
    usr_wdat = '0; usr_wstrb = '0; usr_wvalid = 0; usr_rready = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    #1;
    chk("rst_ready", usr_ready, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_done", usr_done, 1'b0);
    #21 aresetn = 1'b1;
    cyc();
    chk("post_rst_ready", usr_ready, 1'b1);
    chk("aw_const0", {awlock, awcache, awprot, awqos, awregion, awuser}, 64'd0);
    chk("ar_const0", {arlock, arcache, arprot, arqos, arregion, aruser}, 64'd0);

    // Read len=3 at 0x100, clean response.
    issue(1'b0, 32'h100, 8'd3);
    chk("rd_arvalid", arvalid, 1'b1);
    chk("rd_araddr", araddr, 64'h100);
    chk("rd_arlen", arlen, 64'd3);
    chk("rd_arburst", arburst, 64'd1);
    chk("rd_arsize", arsize, 64'd3);
    chk("rd_arid", arid, 64'd0);
    chk("rd_no_aw", awvalid, 1'b0);
    cyc();
    chk("rd_ar_hold", arvalid, 1'b1);
    chk("rd_araddr_hold", araddr, 64'h100);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    chk("rd_ar_drop", arvalid, 1'b0);
    read_beats(4, -1);
    finish_done(1'b0);

    // Early rlast on beat 0 of a 2-beat read: error, but both beats taken.
    issue(1'b0, 32'h40, 8'd1);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    read_beats(2, 0);
    finish_done(1'b1);

    // Write len=0 at 0x200, awready withheld for 5 cycles.
    usr_wvalid = 1'b1;
    usr_wdat   = 64'h1122_3344_5566_7788;
    usr_wstrb  = 8'hF0;
    wready     = 1'b1;
    issue(1'b1, 32'h200, 8'd0);
    for (int i = 0; i < 5; i++) begin
      chk("wr0_awvalid", awvalid, 1'b1);
      chk("wr0_awaddr", awaddr, 64'h200);
      chk("wr0_awlen", awlen, 64'd0);
      chk("wr0_no_wvalid", wvalid, 1'b0);
      chk("wr0_no_uwready", usr_wready, 1'b0);
      cyc();
    end
    awready = 1'b1;
    chk("wr0_awvalid6", awvalid, 1'b1);
    cyc();
    awready = 1'b0;
    chk("wr0_aw_drop", awvalid, 1'b0);
    chk("wr0_wvalid", wvalid, 1'b1);
    chk("wr0_wlast", wlast, 1'b1);
    chk("wr0_wdata", wdata, 64'h1122_3344_5566_7788);
    chk("wr0_wstrb", wstrb, 64'hF0);
    chk("wr0_uwready", usr_wready, 1'b1);
    cyc();
    usr_wvalid = 1'b0;
    wready     = 1'b0;
    chk("wr0_bready", bready, 1'b1);
    chk("wr0_w_drop", wvalid, 1'b0);
    bvalid = 1'b1;
    cyc();
    bvalid = 1'b0;
    finish_done(1'b0);

    // Write len=7, wready toggling, SLVERR response.
    issue(1'b1, 32'h300, 8'd7);
    awready = 1'b1;
    cyc();
    awready = 1'b0;
    usr_wvalid = 1'b1;
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      wready   = (c % 2 == 1);
      usr_wdat = 64'hA0 + 64'(beats);
      #1;
      chk("wr7_wvalid", wvalid, 1'b1);
      chk("wr7_wlast", wlast, beats == 7);
      chk("wr7_wdata", wdata, 64'hA0 + 64'(beats));
      chk("wr7_uwready", usr_wready, wready);
      if (wready) beats++;
      cyc();
    end
    chk("wr7_beats", beats, 64'd8);
    wready     = 1'b0;
    usr_wvalid = 1'b0;
    chk("wr7_w_done", wvalid, 1'b0);
    chk("wr7_bready", bready, 1'b1);
    bvalid = 1'b1;
    bresp  = 2'b10;
    cyc();
    bvalid = 1'b0;
    bresp  = 2'b00;
    finish_done(1'b1);

    // Read len=255: full 256 beats, no counter wrap.
    issue(1'b0, 32'h1000, 8'd255);
    chk("rd255_arlen", arlen, 64'd255);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    read_beats(256, -1);
    finish_done(1'b0);

    // 0xFF8 + 2*8 bytes crosses 4KB: rejected without AXI traffic.
    issue(1'b0, 32'hFF8, 8'd1);
    chk("bnd_no_ar", arvalid, 1'b0);
    chk("bnd_no_aw", awvalid, 1'b0);
    finish_done(1'b1);
    // 0xFF0 + 16 ends exactly on the page: allowed.
    issue(1'b0, 32'hFF0, 8'd1);
    chk("bnd_ok_ar", arvalid, 1'b1);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    read_beats(2, -1);
    finish_done(1'b0);

    // Reset asserted during write beat 2.
    issue(1'b1, 32'h400, 8'd3);
    awready = 1'b1;
    cyc();
    awready    = 1'b0;
    usr_wvalid = 1'b1;
    wready     = 1'b1;
    cyc();
    chk("rst_w_beat2", wvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("rstw_wvalid", wvalid, 1'b0);
    chk("rstw_awvalid", awvalid, 1'b0);
    chk("rstw_bready", bready, 1'b0);
    chk("rstw_done", usr_done, 1'b0);
    usr_wvalid = 1'b0;
    wready     = 1'b0;
    cyc();
    #2 aresetn = 1'b1;
    cyc();
    chk("rstw_ready", usr_ready, 1'b1);
    chk("rstw_wvalid2", wvalid, 1'b0);
    chk("rstw_done2", usr_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
